// File: rtl/bcd_convert_arbiter_if.sv
// bcd_convert_arbiter_if: request and result bundle for the shared binary-to-BCD converter.
interface bcd_convert_arbiter_if #(parameter int WIDTH = 16, parameter int DIGITS = 5);
    logic in_valid0, in_ready0, in_valid1, in_ready1;
    logic [WIDTH-1:0] in_bin0, in_bin1;
    logic res_valid, res_ready, res_id, res_ovf, busy;
    logic [4*DIGITS-1:0] res_bcd;
    modport master (
        output in_valid0, in_bin0, in_valid1, in_bin1, res_ready,
        input in_ready0, in_ready1, res_valid, res_bcd, res_id, res_ovf, busy
    );
    modport slave (
        input in_valid0, in_bin0, in_valid1, in_bin1, res_ready,
        output in_ready0, in_ready1, res_valid, res_bcd, res_id, res_ovf, busy
    );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// bcd_convert_arbiter: round-robin shared serial double-dabble binary-to-BCD converter.
// Define BCD_FAST_START_EN to skip leading zeros with a priority encoder at load time.
module bcd_convert_arbiter #(
    parameter int WIDTH = 16,
    parameter int DIGITS = 5
) (
    input logic clk,
    input logic rst_n,
    bcd_convert_arbiter_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_next;
    logic last_grant, grant, ready0, ready1, done, active, accept, id, ovf;
    logic [WIDTH-1:0] bin, sel_bin, load_bin;
    logic [BW-1:0] bcd, adj;
    logic [CW-1:0] count, load_cnt;

    assign grant = (bus.in_valid0 && bus.in_valid1) ? !last_grant : bus.in_valid1;
    assign sel_bin = grant ? bus.in_bin1 : bus.in_bin0;
    assign accept = ready0 || ready1;

`ifdef BCD_FAST_START_EN
    logic [CW-1:0] msb;
    always_comb begin
        msb = '0;
        for (int i = 0; i < WIDTH; i++)
            if (sel_bin[i]) msb = i[CW-1:0];
    end
    // Leading zeros contribute nothing to the BCD digits, so they are skipped outright.
    assign load_bin = sel_bin << (CW'(WIDTH - 1) - msb);
    assign load_cnt = msb + CW'(1);
`else
    assign load_bin = sel_bin;
    assign load_cnt = CW'(WIDTH);
`endif

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? SHIFT : IDLE;
            SHIFT:   state_next = (count == CW'(1)) ? DONE : SHIFT;
            DONE:    state_next = bus.res_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready0 = state == IDLE && bus.in_valid0 && !grant;
        ready1 = state == IDLE && bus.in_valid1 && grant;
        done = state == DONE;
        active = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bin <= '0;
            bcd <= '0;
            ovf <= 1'b0;
            id <= 1'b0;
            last_grant <= 1'b1;
            count <= '0;
        end else if (accept) begin
            bin <= load_bin;
            bcd <= '0;
            ovf <= 1'b0;
            id <= grant;
            last_grant <= grant;
            count <= load_cnt;
        end else if (state == SHIFT) begin
            {bcd, bin} <= {adj[BW-2:0], bin, 1'b0};
            ovf <= ovf | adj[BW-1];
            count <= count - CW'(1);
        end

    assign bus.in_ready0 = ready0;
    assign bus.in_ready1 = ready1;
    assign bus.res_valid = done;
    assign bus.busy = active;
    assign bus.res_bcd = bcd;
    assign bus.res_id = id;
    assign bus.res_ovf = ovf;
endmodule
